// File: rtl/plab2_proc_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the iteration-counter width helper.
package plab2_proc_muldiv_pkg;

    typedef enum logic [2:0] {
        FUNC_MUL  = 3'd0,
        FUNC_DIV  = 3'd1,
        FUNC_DIVU = 3'd2,
        FUNC_REM  = 3'd3,
        FUNC_REMU = 3'd4
    } func_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must be able to hold the operand width itself.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(32);

    // Unused codes 5-7 fold onto MUL.
    function automatic func_e decode_func(input logic [2:0] code);
        func_e f;
        case (code)
            3'd1:    f = FUNC_DIV;
            3'd2:    f = FUNC_DIVU;
            3'd3:    f = FUNC_REM;
            3'd4:    f = FUNC_REMU;
            default: f = FUNC_MUL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/plab2_proc_muldiv_iter_ctrl.sv
// Control FSM and iteration counter for the iterative multiply/divide unit.
module plab2_proc_muldiv_iter_ctrl
    import plab2_proc_muldiv_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   in_val,
    input  logic   out_rdy,
    input  logic   flush,
    input  logic   is_mul,
    input  logic   mul_last,
    input  logic   div_zero,
    output logic   in_rdy,
    output logic   out_val,
    output logic   accept,
    output logic   calc_last,
    output logic   go_idle,
    output state_e state
);

    localparam int CW = cnt_width(p_nbits);
    localparam logic [CW-1:0] LAST_CNT = CW'(p_nbits - 1);

    state_e          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        in_rdy     = (state_reg == ST_IDLE) && reset;
        out_val    = (state_reg == ST_DONE);
        accept     = in_rdy && in_val && !flush;
        calc_last  = (state_reg == ST_CALC) &&
                     (is_mul ? mul_last : (div_zero || cnt_reg == LAST_CNT));

        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_CALC;
            ST_CALC: begin
                cnt_next = cnt_reg + 1'b1;
                if (calc_last) state_next = ST_DONE;
            end
            ST_DONE: if (out_rdy) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Abort wins over any handshake happening in the same cycle.
        if (flush) state_next = ST_IDLE;
        if (state_next != ST_CALC) cnt_next = '0;

        go_idle = (state_next == ST_IDLE);
        state   = state_reg;
    end

endmodule

// File: rtl/plab2_proc_muldiv_iter_unit.sv
// Iterative multiply/divide unit: shift-add multiply with early exit and
// restoring division on magnitudes, with domain tagging and flush.
module plab2_proc_muldiv_iter_unit
    import plab2_proc_muldiv_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               domain,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [2:0]         in_func,
    input  logic [p_nbits-1:0] in_a,
    input  logic [p_nbits-1:0] in_b,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               out_domain,
    input  logic               flush
);

    localparam int N = p_nbits;

    logic [N-1:0] a_reg, a_next, b_reg, b_next;
    logic [N-1:0] acc_reg, acc_next, result_reg, result_next;
    func_e        func_reg, func_next, func_in;
    logic         domain_reg, domain_next;
    logic         neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;

    logic         accept, calc_last, go_idle;
    logic         is_mul, is_rem, div_zero, mul_last;
    logic         in_signed, a_neg, b_neg;
    state_e       state;

    logic [N-1:0] mul_sum;
    logic [N:0]   div_shift;
    logic         div_ge;
    logic [N-1:0] div_rem, div_quo;

    plab2_proc_muldiv_iter_ctrl #(.p_nbits(p_nbits)) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .in_val    (in_val),
        .out_rdy   (out_rdy),
        .flush     (flush),
        .is_mul    (is_mul),
        .mul_last  (mul_last),
        .div_zero  (div_zero),
        .in_rdy    (in_rdy),
        .out_val   (out_val),
        .accept    (accept),
        .calc_last (calc_last),
        .go_idle   (go_idle),
        .state     (state)
    );

    assign is_mul   = (func_reg == FUNC_MUL);
    assign is_rem   = (func_reg == FUNC_REM) || (func_reg == FUNC_REMU);
    assign div_zero = (b_reg == '0);
    assign mul_last = (b_reg[N-1:1] == '0);

    assign func_in   = decode_func(in_func);
    assign in_signed = (func_in == FUNC_DIV) || (func_in == FUNC_REM);
    assign a_neg     = in_signed && in_a[N-1];
    assign b_neg     = in_signed && in_b[N-1];

    assign mul_sum   = acc_reg + (b_reg[0] ? a_reg : '0);
    assign div_shift = {acc_reg, a_reg[N-1]};
    assign div_ge    = (div_shift >= {1'b0, b_reg});
    // When div_ge holds the true difference is below b_reg, so N bits suffice.
    assign div_rem   = div_ge ? (div_shift[N-1:0] - b_reg) : div_shift[N-1:0];
    assign div_quo   = {a_reg[N-2:0], div_ge};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            func_reg   <= FUNC_MUL;
            domain_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else begin
            a_reg      <= a_next;
            b_reg      <= b_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            func_reg   <= func_next;
            domain_reg <= domain_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
        end
    end

    always_comb begin
        a_next      = a_reg;
        b_next      = b_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        func_next   = func_reg;
        domain_next = domain_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;

        // Scrub everything whenever we land in IDLE so nothing leaks across domains.
        if (go_idle) begin
            a_next      = '0;
            b_next      = '0;
            acc_next    = '0;
            result_next = '0;
            func_next   = FUNC_MUL;
            domain_next = 1'b0;
            neg_q_next  = 1'b0;
            neg_r_next  = 1'b0;
        end else if (accept) begin
            func_next   = func_in;
            domain_next = domain;
            a_next      = a_neg ? -in_a : in_a;
            b_next      = b_neg ? -in_b : in_b;
            neg_q_next  = a_neg ^ b_neg;
            neg_r_next  = a_neg;
            acc_next    = '0;
            result_next = '0;
        end else if (state == ST_CALC) begin
            if (is_mul) begin
                acc_next = mul_sum;
                a_next   = a_reg << 1;
                b_next   = b_reg >> 1;
                if (calc_last) result_next = mul_sum;
            end else if (div_zero) begin
                result_next = is_rem ? (neg_r_reg ? -a_reg : a_reg) : '1;
            end else begin
                acc_next = div_rem;
                a_next   = div_quo;
                if (calc_last)
                    result_next = is_rem ? (neg_r_reg ? -div_rem : div_rem)
                                         : (neg_q_reg ? -div_quo : div_quo);
            end
        end
    end

    assign out_msg    = (state == ST_DONE) ? result_reg : '0;
    assign out_domain = (state == ST_DONE) ? domain_reg : 1'b0;

endmodule

// File: doc/plab2_proc_muldiv_iter_unit.md
PLAB2_PROC_MULDIV_ITER_UNIT -- requirements
Module: plab2_proc_muldiv_iter_unit

Interface
REQ-001 SHALL have parameter p_nbits, default 32, operand/result width.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port domain, input, 1, security domain of the offered request.
REQ-005 SHALL have ports in_val input 1 and in_rdy output 1, the request handshake.
REQ-006 SHALL have port in_func, input, 3, operation code: MUL=0, DIV=1, DIVU=2, REM=3, REMU=4; codes 5-7 behave as MUL.
REQ-007 SHALL have ports in_a and in_b, input, p_nbits, operands (dividend/multiplicand, divisor/multiplier).
REQ-008 SHALL have ports out_val output 1 and out_rdy input 1, the response handshake.
REQ-009 SHALL have port out_msg, output, p_nbits, result.
REQ-010 SHALL have port out_domain, output, 1, domain captured with the request.
REQ-011 SHALL have port flush, input, 1, synchronous abort.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE; in_rdy = 1 only in IDLE with reset deasserted; out_val = 1 only in DONE.
REQ-013 SHALL accept a request in the cycle where in_val && in_rdy && !flush (cycle 0), capturing operands, func and domain, and enter CALC.
REQ-014 SHALL for MUL compute low p_nbits of a*b by shift-add, one multiplier bit per cycle; CALC lasts max(1, bitlen(b)) cycles (early termination when remaining multiplier is zero).
REQ-015 SHALL for DIV/DIVU/REM/REMU use restoring division on magnitudes, one quotient bit per cycle; CALC lasts exactly p_nbits cycles.
REQ-016 SHALL for signed ops negate the quotient when sign(a) != sign(b) and give the remainder the sign of a.
REQ-017 SHALL on divisor zero spend 1 CALC cycle and return all-ones for DIV/DIVU and a unchanged for REM/REMU.
REQ-018 SHALL for DIV of most-negative by -1 return most-negative, and return 0 for the corresponding REM.
REQ-019 SHALL enter DONE in cycle k+1, where k is the CALC length; out_msg and out_domain SHALL hold stable while out_val && !out_rdy.
REQ-020 SHALL return to IDLE the cycle after out_val && out_rdy; there is no back-to-back accept (in_rdy = 0 in DONE).
REQ-021 SHALL on flush in any state go to IDLE on the next edge, drop the in-flight operation, and never assert out_val for it; flush overrides a simultaneous accept or response.
REQ-022 SHALL zero operand, accumulator, result and captured-domain registers on every entry to IDLE, so no data from a previous domain persists.
REQ-023 SHALL drive out_msg = 0 and out_domain = 0 outside DONE.

Reset
REQ-024 SHALL on reset low immediately force IDLE, all datapath registers and counters to 0, and in_rdy = 0 and out_val = 0.
REQ-025 SHALL accept a new request no earlier than the first rising edge after reset deassertion; reset mid-CALC discards the operation with no response.

Structure
REQ-026 SHALL place func encodings, state encodings and the operation-count width ($clog2(p_nbits)+1) in a shared package plab2_proc_muldiv_pkg.
REQ-027 SHALL split into a control FSM/counter sub-module plab2_proc_muldiv_iter_ctrl plus an inline datapath.

Verification
REQ-028 SHALL cover: MUL 6*7 accepted in cycle 0 -> out_msg 42, out_val first high in cycle 4 (bitlen(7) = 3).
REQ-029 SHALL cover: DIV -7/2 -> 0xFFFFFFFD, and REM -7/2 -> 0xFFFFFFFF, out_val in cycle 33.
REQ-030 SHALL cover: DIVU 5/0 -> 0xFFFFFFFF, and REMU 5/0 -> 5, out_val in cycle 2.
REQ-031 SHALL cover: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, and REM -> 0.
REQ-032 SHALL cover: with domain = 1, MUL 3*3 and out_rdy held low 5 cycles -> out_msg 9 and out_domain 1 stable, in_rdy 0; then out_rdy high -> IDLE with registers zeroed.
REQ-033 SHALL cover: DIVU started then flush in cycle 10 -> IDLE in cycle 11, no out_val; repeat with reset low in cycle 10 -> same outcome, with in_rdy 0 while reset is low.
